exp_pipe_array: RTL and testbench

//  Multi-lane pipelined fixed-point exp(x) for the softmax datapath; successor to the single-lane exp unit.

---
 rtl/exp_pkg.sv | 16 +
 rtl/exp_lane.sv | 92 +++++++++
 rtl/exp_pipe_array.sv | 98 +++++++++
 tb/tb_exp_pipe_array.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exp_pkg.sv
// exp_pkg: constants shared by the softmax exp datapath.
// Q16 polynomial coefficients, output clamps, exponent limits.
package exp_pkg;

  localparam int LOG2E_Q16 = 94548;
  localparam int C1_Q16    = 43024;
  localparam int C2_Q16    = 22512;

  localparam logic [15:0] OUT_MAX = 16'h7FFF;
  localparam logic [15:0] OUT_MIN = 16'h0001;

  localparam int K_MIN = -64;
  localparam int K_MAX = 63;
  localparam int K_W   = 7;

endpackage

// File: rtl/exp_lane.sv
// exp_lane: one lane of the 3-stage 2^(x*log2e) datapath.
// S1 scales by log2e, S2 splits k/f and evaluates 2^f, S3 shifts.
module exp_lane
  import exp_pkg::*;
#(
  parameter int IN_DATA_WIDTH  = 32,
  parameter int IN_FRAC        = 16,
  parameter int OUT_DATA_WIDTH = 16,
  parameter int FRACTION_WIDTH = 10
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic [IN_DATA_WIDTH-1:0]  x,
  output logic [OUT_DATA_WIDTH-1:0] y,
  output logic                      sat
);

  localparam int PW    = IN_DATA_WIDTH + 18;
  localparam int FB    = IN_FRAC + 16;
  localparam int PH    = PW - FB + 16;
  localparam int KW    = PH - 16;
  localparam int SAT_K = OUT_DATA_WIDTH - 1 - FRACTION_WIDTH;

  logic signed [PH-1:0]  p_d, p_q;
  logic signed [KW-1:0]  k_full;
  logic [15:0]           f;
  logic [15:0]           t1;
  logic [16:0]           t2;
  logic [17:0]           t3;
  logic signed [K_W-1:0] k_d, k_q;
  logic [17:0]           m_d, m_q;
  logic signed [7:0]     sh;
  logic [63:0]           y_w;
  logic [OUT_DATA_WIDTH-1:0] y_d;
  logic                  sat_d;

  // Only the integer part and top 16 fraction bits are kept.
  assign p_d = PH'((PW'($signed(x)) * PW'(LOG2E_Q16)) >>> (FB - 16));

  assign k_full = $signed(p_q[PH-1:16]);
  assign f      = p_q[15:0];

  // S2: clamp exponent, evaluate m = 1 + f*(C1 + f*C2) in Q1.16
  always_comb begin
    t1  = 16'((32'(f) * 32'(C2_Q16)) >> 16);
    t2  = 17'(C1_Q16) + 17'(t1);
    t3  = 18'((34'(f) * 34'(t2)) >> 16);
    m_d = 18'(18'h10000 + t3);
    if (k_full < KW'(K_MIN))
      k_d = K_W'(K_MIN);
    else if (k_full > KW'(K_MAX))
      k_d = K_W'(K_MAX);
    else
      k_d = K_W'(k_full);
  end

  // S3: scale mantissa into output format, clamp high and low
  always_comb begin
    sh = 8'(k_q) + 8'(FRACTION_WIDTH - 16);
    if (sh[7])
      y_w = 64'(m_q) >> 8'(-sh);
    else
      y_w = 64'(m_q) << sh;
    y_d   = y_w[OUT_DATA_WIDTH-1:0];
    sat_d = 1'b0;
    if (k_q >= K_W'(SAT_K) || y_w > 64'(OUT_MAX)) begin
      y_d   = OUT_DATA_WIDTH'(OUT_MAX);
      sat_d = 1'b1;
    end else if (y_w == '0) begin
      y_d = OUT_DATA_WIDTH'(OUT_MIN);
    end
  end

  // Pipeline registers, all frozen together by en
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q <= '0;
      k_q <= '0;
      m_q <= '0;
      y   <= '0;
      sat <= 1'b0;
    end else if (en) begin
      p_q <= p_d;
      k_q <= k_d;
      m_q <= m_d;
      y   <= y_d;
      sat <= sat_d;
    end
  end

endmodule

// File: rtl/exp_pipe_array.sv
// exp_pipe_array: multi-lane pipelined exp with handshake,
// lane masking and a saturating per-row sum for softmax.
module exp_pipe_array
  import exp_pkg::*;
#(
  parameter int LANES          = 4,
  parameter int IN_DATA_WIDTH  = 32,
  parameter int IN_FRAC        = 16,
  parameter int OUT_DATA_WIDTH = 16,
  parameter int FRACTION_WIDTH = 10,
  parameter int SUM_WIDTH      = 32
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            i_valid,
  output logic                            o_ready_in,
  input  logic [LANES*IN_DATA_WIDTH-1:0]  i_data,
  input  logic [LANES-1:0]                i_mask,
  input  logic                            i_last,
  output logic                            o_valid,
  input  logic                            i_ready,
  output logic [LANES*OUT_DATA_WIDTH-1:0] o_data,
  output logic [LANES-1:0]                o_sat,
  output logic                            o_last,
  output logic [SUM_WIDTH-1:0]            o_sum
);

  localparam int IW  = IN_DATA_WIDTH;
  localparam int OW  = OUT_DATA_WIDTH;
  localparam int LSW = OW + $clog2(LANES) + 1;
  localparam int SW1 = SUM_WIDTH + 1;

  logic                        en;
  logic [2:0]                  v_q;
  logic [2:0]                  l_q;
  logic [2:0][LANES-1:0]       m_q;
  logic [OW-1:0]               y [LANES];
  logic [LANES-1:0]            sat;
  logic [LSW-1:0]              lsum;
  logic [SW1-1:0]              sum_full;
  logic [SUM_WIDTH-1:0]        sum_sat;
  logic [SUM_WIDTH-1:0]        acc_q;

  assign en         = ~(o_valid & ~i_ready);
  assign o_ready_in = en;
  assign o_valid    = v_q[2];
  assign o_last     = l_q[2];

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    exp_lane #(
      .IN_DATA_WIDTH (IW),
      .IN_FRAC       (IN_FRAC),
      .OUT_DATA_WIDTH(OW),
      .FRACTION_WIDTH(FRACTION_WIDTH)
    ) u_lane (
      .clk  (clk),
      .rst_n(rst_n),
      .en   (en),
      .x    (i_valid ? i_data[g*IW +: IW] : '0),
      .y    (y[g]),
      .sat  (sat[g])
    );
    assign o_data[g*OW +: OW] = m_q[2][g] ? y[g] : '0;
    assign o_sat[g]           = m_q[2][g] & sat[g];
  end

  // Beat sideband: valid, last and mask travel with the data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= '0;
      l_q <= '0;
      m_q <= '0;
    end else if (en) begin
      v_q <= {v_q[1:0], i_valid};
      l_q <= {l_q[1:0], i_valid & i_last};
      m_q <= {m_q[1:0], i_valid ? i_mask : '0};
    end
  end

  // Lane sum of the output beat; masked lanes are already zero
  always_comb begin
    lsum = '0;
    for (int i = 0; i < LANES; i++)
      lsum = lsum + LSW'(o_data[i*OW +: OW]);
    sum_full = SW1'(acc_q) + SW1'(lsum);
    sum_sat  = sum_full[SUM_WIDTH] ? '1 : sum_full[SUM_WIDTH-1:0];
    o_sum    = (o_valid & o_last) ? sum_sat : '0;
  end

  // Row accumulator advances on each transfer, clears on last
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      acc_q <= '0;
    else if (o_valid & i_ready)
      acc_q <= o_last ? '0 : sum_sat;
  end

endmodule

// File: tb/tb_exp_pipe_array.sv
// tb_exp_pipe_array: directed checks of the exp pipeline array.
// Output transfers are logged at negedge and checked per scenario.
module tb_exp_pipe_array;

  localparam int L  = 4;
  localparam int IW = 32;
  localparam int OW = 16;
  localparam int SW = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            i_valid;
  logic            o_ready_in;
  logic [L*IW-1:0] i_data;
  logic [L-1:0]    i_mask;
  logic            i_last;
  logic            o_valid;
  logic            i_ready;
  logic [L*OW-1:0] o_data;
  logic [L-1:0]    o_sat;
  logic            o_last;
  logic [SW-1:0]   o_sum;

  int pass_cnt = 0;
  int total    = 0;
  int cyc      = 0;

  logic [L*OW-1:0] q_data [$];
  logic [L-1:0]    q_sat  [$];
  logic            q_last [$];
  logic [SW-1:0]   q_sum  [$];
  int              q_cyc  [$];

  logic [31:0] xs  [5] = '{32'h0000_0000, 32'h0001_0000, 32'hFFFF_0000,
                           32'h0004_0000, 32'hFFEC_0000};
  int          lo  [5] = '{1024, 2774, 375, 32767, 1};
  int          hi  [5] = '{1024, 2792, 379, 32767, 1};
  logic        sx  [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

  exp_pipe_array dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_valid   (i_valid),
    .o_ready_in(o_ready_in),
    .i_data    (i_data),
    .i_mask    (i_mask),
    .i_last    (i_last),
    .o_valid   (o_valid),
    .i_ready   (i_ready),
    .o_data    (o_data),
    .o_sat     (o_sat),
    .o_last    (o_last),
    .o_sum     (o_sum)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n && o_valid && i_ready) begin
      q_data.push_back(o_data);
      q_sat.push_back(o_sat);
      q_last.push_back(o_last);
      q_sum.push_back(o_sum);
      q_cyc.push_back(cyc);
    end
  end

  task automatic clear_q();
    q_data.delete();
    q_sat.delete();
    q_last.delete();
    q_sum.delete();
    q_cyc.delete();
  endtask

  task automatic send(input logic [L*IW-1:0] d, input logic [L-1:0] m,
                      input logic last, output int acc);
    int t;
    i_valid = 1'b1;
    i_data  = d;
    i_mask  = m;
    i_last  = last;
    t = 0;
    @(negedge clk);
    while (!o_ready_in && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) begin
      total++;
      $display("FAIL send_accept: o_ready_in stuck at %b", o_ready_in);
    end
    @(posedge clk);
    #1;
    acc     = cyc;
    i_valid = 1'b0;
    i_data  = 'x;
    i_mask  = 'x;
    i_last  = 1'bx;
  endtask

  task automatic wait_out(input int n);
    int t;
    t = 0;
    while (q_data.size() < n && t < 100) begin
      @(posedge clk);
      t++;
    end
    #1;
    total++;
    if (q_data.size() >= n) pass_cnt++;
    else $display("FAIL wait_out: got %0d beats want %0d", q_data.size(), n);
  endtask

  task automatic test_reset();
    #2;
    total++;
    if (o_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", o_valid);
    else pass_cnt++;
    total++;
    if (o_data !== '0) $display("FAIL rst_data: got %h want 0", o_data);
    else pass_cnt++;
    total++;
    if ({o_sat, o_last} !== '0) $display("FAIL rst_sat_last: got %b want 0", {o_sat, o_last});
    else pass_cnt++;
    total++;
    if (o_sum !== '0) $display("FAIL rst_sum: got %h want 0", o_sum);
    else pass_cnt++;
    total++;
    if (o_ready_in !== 1'b1) $display("FAIL rst_ready: got %b want 1", o_ready_in);
    else pass_cnt++;
  endtask

  task automatic test_single_lane();
    int acc;
    int v;
    for (int i = 0; i < 5; i++) begin
      clear_q();
      send({96'h0, xs[i]}, 4'b0001, 1'b1, acc);
      wait_out(1);
      if (q_data.size() > 0) begin
        v = int'(q_data[0][15:0]);
        total++;
        if (v >= lo[i] && v <= hi[i]) pass_cnt++;
        else $display("FAIL single%0d_data: got %0d want %0d..%0d", i, v, lo[i], hi[i]);
        total++;
        if (q_sat[0] === {3'b000, sx[i]}) pass_cnt++;
        else $display("FAIL single%0d_sat: got %b want %b", i, q_sat[0], {3'b000, sx[i]});
        total++;
        if (q_data[0][63:16] === 48'h0) pass_cnt++;
        else $display("FAIL single%0d_masked: got %h want 0", i, q_data[0][63:16]);
        total++;
        if (q_last[0] === 1'b1) pass_cnt++;
        else $display("FAIL single%0d_last: got %b want 1", i, q_last[0]);
        total++;
        if (int'(q_sum[0]) >= lo[i] && int'(q_sum[0]) <= hi[i]) pass_cnt++;
        else $display("FAIL single%0d_sum: got %0d want %0d..%0d", i, q_sum[0], lo[i], hi[i]);
        total++;
        if (q_cyc[0] - acc + 1 == 3) pass_cnt++;
        else $display("FAIL single%0d_latency: got %0d want 3", i, q_cyc[0] - acc + 1);
      end
    end
  endtask

  task automatic test_lanes();
    int acc;
    logic [63:0] d;
    clear_q();
    send({32'hFFEC_0000, 32'hFFFF_0000, 32'h0001_0000, 32'h0000_0000},
         4'b1111, 1'b1, acc);
    wait_out(1);
    if (q_data.size() > 0) begin
      d = q_data[0];
      total++;
      if (d[15:0] === 16'h0400) pass_cnt++;
      else $display("FAIL lanes_l0: got %h want 0400", d[15:0]);
      total++;
      if (d[31:16] >= 16'd2774 && d[31:16] <= 16'd2792) pass_cnt++;
      else $display("FAIL lanes_l1: got %0d want 2774..2792", d[31:16]);
      total++;
      if (d[47:32] >= 16'd375 && d[47:32] <= 16'd379) pass_cnt++;
      else $display("FAIL lanes_l2: got %0d want 375..379", d[47:32]);
      total++;
      if (d[63:48] === 16'h0001) pass_cnt++;
      else $display("FAIL lanes_l3: got %h want 0001", d[63:48]);
      total++;
      if (q_sat[0] === 4'b0000) pass_cnt++;
      else $display("FAIL lanes_sat: got %b want 0000", q_sat[0]);
      total++;
      if (q_sum[0] >= 32'd4174 && q_sum[0] <= 32'd4196) pass_cnt++;
      else $display("FAIL lanes_sum: got %0d want 4174..4196", q_sum[0]);
    end
  endtask

  task automatic test_row();
    int acc;
    logic [63:0] e;
    logic        el;
    clear_q();
    send('0, 4'b0111, 1'b0, acc);
    send('0, 4'b0111, 1'b0, acc);
    send('0, 4'b0111, 1'b1, acc);
    send('0, 4'b0001, 1'b1, acc);
    wait_out(4);
    if (q_data.size() >= 4) begin
      for (int i = 0; i < 4; i++) begin
        e  = (i < 3) ? 64'h0000_0400_0400_0400 : 64'h0000_0000_0000_0400;
        el = (i >= 2);
        total++;
        if (q_data[i] === e) pass_cnt++;
        else $display("FAIL row_data%0d: got %h want %h", i, q_data[i], e);
        total++;
        if (q_last[i] === el) pass_cnt++;
        else $display("FAIL row_last%0d: got %b want %b", i, q_last[i], el);
      end
      total++;
      if (q_sum[2] === 32'd9216) pass_cnt++;
      else $display("FAIL row_sum: got %0d want 9216", q_sum[2]);
      total++;
      if (q_sum[3] === 32'd1024) pass_cnt++;
      else $display("FAIL row_next_sum: got %0d want 1024", q_sum[3]);
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] held;
    logic [63:0] e;
    logic [3:0]  m;
    clear_q();
    fork
      begin
        int acc;
        for (int i = 0; i < 10; i++) begin
          m = 4'(i + 1);
          send('0, m, i == 9, acc);
        end
      end
      begin
        repeat (4) @(posedge clk);
        #1;
        i_ready = 1'b0;
        held = o_data;
        for (int c = 0; c < 5; c++) begin
          @(negedge clk);
          total++;
          if (o_ready_in === 1'b0) pass_cnt++;
          else $display("FAIL bp_ready%0d: got %b want 0", c, o_ready_in);
          total++;
          if (o_valid === 1'b1) pass_cnt++;
          else $display("FAIL bp_valid%0d: got %b want 1", c, o_valid);
          total++;
          if (o_data === held) pass_cnt++;
          else $display("FAIL bp_stable%0d: got %h want %h", c, o_data, held);
        end
        @(posedge clk);
        #1;
        i_ready = 1'b1;
      end
    join
    wait_out(10);
    repeat (4) @(posedge clk);
    #1;
    total++;
    if (q_data.size() == 10) pass_cnt++;
    else $display("FAIL bp_count: got %0d want 10", q_data.size());
    if (q_data.size() >= 10) begin
      for (int i = 0; i < 10; i++) begin
        m = 4'(i + 1);
        for (int l = 0; l < 4; l++)
          e[l*16 +: 16] = m[l] ? 16'h0400 : 16'h0000;
        total++;
        if (q_data[i] === e && q_last[i] === (i == 9)) pass_cnt++;
        else $display("FAIL bp_beat%0d: got %h/%b want %h/%b",
                      i, q_data[i], q_last[i], e, i == 9);
      end
      total++;
      if (q_sum[9] === 32'd17408) pass_cnt++;
      else $display("FAIL bp_sum: got %0d want 17408", q_sum[9]);
    end
  endtask

  task automatic test_reset_mid_row();
    int acc;
    clear_q();
    send('0, 4'b1111, 1'b0, acc);
    send('0, 4'b1111, 1'b0, acc);
    rst_n = 1'b0;
    @(negedge clk);
    total++;
    if (o_valid === 1'b0 && o_sum === '0) pass_cnt++;
    else $display("FAIL midrst_valid: got %b/%h want 0/0", o_valid, o_sum);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send('0, 4'b1111, 1'b1, acc);
    wait_out(1);
    repeat (4) @(posedge clk);
    #1;
    total++;
    if (q_data.size() == 1) pass_cnt++;
    else $display("FAIL midrst_count: got %0d want 1", q_data.size());
    if (q_data.size() > 0) begin
      total++;
      if (q_sum[0] === 32'd4096) pass_cnt++;
      else $display("FAIL midrst_sum: got %0d want 4096", q_sum[0]);
      total++;
      if (q_data[0] === 64'h0400_0400_0400_0400) pass_cnt++;
      else $display("FAIL midrst_data: got %h want 0400 x4", q_data[0]);
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    i_valid = 1'b0;
    i_ready = 1'b1;
    i_data  = '0;
    i_mask  = '0;
    i_last  = 1'b0;
    test_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    test_single_lane();
    test_lanes();
    test_row();
    test_backpressure();
    test_reset_mid_row();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
